// File: rtl/uart_result_tx.sv
// uart_result_tx: small byte FIFO feeding an 8N1 serial transmitter.
// Result bytes enter through a valid/ready handshake. They leave LSB first
// on the tx pin at CLKS_PER_BIT clocks per bit. Back-to-back frames have no idle gap.
module uart_result_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud, baud_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          push, pop, baud_done;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;

  // The pointers carry one extra wrap bit, so their difference is the occupancy.
  assign fifo_count = wr_ptr - rd_ptr;
  assign tx_ready   = (fifo_count != FULL);
  assign push       = tx_valid && tx_ready;
  assign baud_done  = (baud == BAUD_LAST);
  assign tx_busy    = (state != IDLE);

  // FIFO storage: capture the byte at push time so later tx_data changes cannot affect it
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  // FIFO pointers: reset flushes the queue, including any bytes still waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Frame sequencer registers, with tx registered so the pin never glitches
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
    end
  end

  // Next-state logic; the next line level is derived from the next state and shifter
  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    tx_nxt      = 1'b1;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (fifo_count != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr[AW-1:0]];
          state_nxt = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_nxt    = '0;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_nxt    = '0;
          shift_nxt   = {1'b0, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (fifo_count != '0) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr[AW-1:0]];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx. A frame-timeline model predicts the outputs on every cycle.
// A line decoder recovers the bytes actually sent, and directed scenarios pin literal values.
module tb_uart_result_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, tx_busy;
  logic [2:0] fifo_count;

  int n_assert = 0;
  int n_fail   = 0;

  uart_result_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Model: a queue of accepted bytes plus the position inside the current frame (-1 = idle)
  logic [7:0] m_q[$];
  logic [7:0] m_cur = 8'h00;
  int         m_pos = -1;

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    int k;
    k = pos / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Model update on each edge: pop decisions use the pre-edge queue, then the push lands
  always @(posedge clk) begin : model
    bit ready_pre;
    ready_pre = (m_q.size() < DEPTH);
    if (reset) begin
      m_q.delete();
      m_pos = -1;
    end else begin
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == 10 * CPB) begin
          if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            m_pos = 0;
          end else begin
            m_pos = -1;
          end
        end
      end else if (m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_pos = 0;
      end
      if (tx_valid && ready_pre) m_q.push_back(tx_data);
    end
  end

  // Line decoder: finds a start bit and samples each data bit mid-bit
  logic [7:0] dec_q[$];
  int         dec_t  = -1;
  logic [7:0] dec_sh = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      dec_t = -1;
    end else if (dec_t < 0) begin
      if (tx == 1'b0) dec_t = 0;
    end else begin
      dec_t++;
      if ((dec_t % CPB) == CPB / 2 && dec_t > CPB) begin
        if (dec_t < 9 * CPB) begin
          dec_sh = {tx, dec_sh[7:1]};
        end else begin
          dec_q.push_back(dec_sh);
          dec_t = -1;
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance n cycles, comparing every DUT output against the model after each edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("model_tx", tx, (m_pos < 0) ? 1 : int'(frame_bit(m_cur, m_pos)));
      chk("model_busy", tx_busy, (m_pos >= 0) ? 1 : 0);
      chk("model_count", fifo_count, m_q.size());
      chk("model_ready", tx_ready, (m_q.size() < DEPTH) ? 1 : 0);
    end
  endtask

  task automatic push1(input logic [7:0] b);
    logic r;
    int   g;
    g = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    do begin
      r = tx_ready;
      cyc(1);
      g++;
    end while (!r && g < 200);
    chk("push_accept", r, 1);
  endtask

  task automatic wait_idle(input int limit);
    int g;
    g = 0;
    while ((tx_busy || fifo_count != 0) && g < limit) begin
      cyc(1);
      g++;
    end
    chk("idle_timeout", (tx_busy || fifo_count != 0) ? 1 : 0, 0);
    cyc(2);
  endtask

  logic [7:0] exp_q[$];
  int         dec_rd = 0;

  task automatic check_dec(input string name);
    chk({name, "_n"}, dec_q.size() - dec_rd, exp_q.size());
    for (int i = 0; i < exp_q.size() && dec_rd + i < dec_q.size(); i++)
      chk(name, dec_q[dec_rd + i], exp_q[i]);
    dec_rd = dec_q.size();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, g, nz;

    // Reset state
    reset = 1'b1;
    cyc(2);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_count", fifo_count, 0);
    reset = 1'b0;
    cyc(2);

    // Single byte 0x55 from idle: frame starts the edge after the push, busy for 40 cycles
    push1(8'h55);
    tx_valid = 1'b0;
    chk("t1_tx_after_push", tx, 1);
    chk("t1_count_push", fifo_count, 1);
    cyc(1);
    chk("t1_tx_start", tx, 0);
    chk("t1_busy_start", tx_busy, 1);
    chk("t1_count_pop", fifo_count, 0);
    nb = 1;
    g  = 0;
    while (tx_busy && g < 100) begin
      cyc(1);
      if (tx_busy) nb++;
      g++;
    end
    chk("t1_busy_len", nb, 40);
    cyc(2);
    exp_q = '{8'h55};
    check_dec("t1_dec");

    // Three consecutive pushes: count goes 0,1,1,2, and frames run back to back
    chk("t2_count0", fifo_count, 0);
    push1(8'hA3);
    chk("t2_count1", fifo_count, 1);
    push1(8'h0F);
    chk("t2_count2", fifo_count, 1);
    push1(8'hFF);
    chk("t2_count3", fifo_count, 2);
    tx_valid = 1'b0;
    wait_idle(400);
    exp_q = '{8'hA3, 8'h0F, 8'hFF};
    check_dec("t2_dec");

    // Overfill: 1 byte in flight plus 5 held-valid pushes; the 5th waits for the next pop
    push1(8'hB0);
    push1(8'h11);
    push1(8'h22);
    push1(8'h33);
    push1(8'h44);
    chk("t3_full_ready", tx_ready, 0);
    chk("t3_full_count", fifo_count, 4);
    push1(8'h55);
    tx_valid = 1'b0;
    chk("t3_count_after", fifo_count, 4);
    wait_idle(600);
    exp_q = '{8'hB0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    check_dec("t3_dec");

    // Valid held high with changing data while full: nothing accepted
    push1(8'hC0);
    push1(8'hC1);
    push1(8'hC2);
    push1(8'hC3);
    push1(8'hC4);
    for (int i = 0; i < 20; i++) begin
      tx_data  = 8'($urandom);
      tx_valid = 1'b1;
      cyc(1);
      chk("t6_ready_low", tx_ready, 0);
    end
    tx_valid = 1'b0;
    chk("t6_count", fifo_count, 4);
    wait_idle(600);
    exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    check_dec("t6_dec");

    // Reset during data bit 3 with 2 bytes queued: line idles, queue flushed, nothing resent
    push1(8'h96);
    push1(8'h5A);
    push1(8'h3C);
    tx_valid = 1'b0;
    chk("t4_count", fifo_count, 2);
    cyc(15);
    chk("t4_bit3", tx, 0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t4_rst_tx", tx, 1);
    chk("t4_rst_busy", tx_busy, 0);
    chk("t4_rst_count", fifo_count, 0);
    chk("t4_rst_ready", tx_ready, 1);
    nz = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (tx == 1'b0 || tx_busy) nz++;
    end
    chk("t4_no_frames", nz, 0);
    exp_q.delete();
    check_dec("t4_dec");

    // Push on the same edge as the stop-to-start pop with count 2: count stays 2
    push1(8'hE1);
    push1(8'hD2);
    push1(8'hC3);
    tx_valid = 1'b0;
    cyc(38);
    chk("t5_stop_bit", tx, 1);
    chk("t5_count_before", fifo_count, 2);
    push1(8'hB4);
    tx_valid = 1'b0;
    chk("t5_count_same", fifo_count, 2);
    chk("t5_next_start", tx, 0);
    wait_idle(400);
    exp_q = '{8'hE1, 8'hD2, 8'hC3, 8'hB4};
    check_dec("t5_dec");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_result_tx.md
Name: uart_result_tx

Overview:
- Serial UART transmitter that returns CPU result bytes to the host. It is the transmit counterpart of the receive path that supplies bytes to the register file.
- Accepts 8-bit result bytes from the core through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as 8N1: one start bit, 8 data bits LSB first, one stop bit, at a fixed baud set by parameter.
- Sits between the core's result output and the board TX pin.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud). Legal range is 2 or more.
- FIFO_DEPTH, 4, byte-buffer depth. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte. A push occurs on a rising edge where tx_valid && tx_ready.
- tx  output  1  serial line. Idle level is 1.
- tx_busy  output  1  a frame is currently on the line (start through stop).
- fifo_count  output  log2(FIFO_DEPTH)+1  number of bytes buffered, excluding the byte being sent.

Behaviour:
- Reset (one clk edge with reset=1):
  - tx=1, tx_busy=0, tx_ready=1, fifo_count=0.
  - FSM goes to IDLE, FIFO pointers and baud/bit counters clear.
  - Reset overrides every other input in the same cycle.
- Reset mid-frame: at the next edge tx returns to 1 and the FIFO is flushed. The truncated frame is not resent.
- tx_ready = (fifo_count < FIFO_DEPTH), registered-equivalent, with no combinational path from tx_valid.
- Push when full is impossible because tx_ready=0. A push with tx_valid=1, tx_ready=0 is ignored; data is dropped and state is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, tx_busy=0. If FIFO is non-empty: pop the head into shift register, clear baud counter, go to START.
  - START: tx=0. After CLKS_PER_BIT cycles go to DATA with bit index 0.
  - DATA: tx=shift[0]. Every CLKS_PER_BIT cycles shift right and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: tx=1. After CLKS_PER_BIT cycles:
    - if FIFO is non-empty, pop and go directly to START (no idle bit between frames);
    - else go to IDLE.
- tx_busy=1 in START, DATA and STOP.
- tx is driven from a flop; no glitches.
- Latency: with FSM in IDLE and FIFO empty, a byte pushed at edge N is popped at edge N+1. tx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles, from the tx falling edge to the end of the stop bit.
- Simultaneous push and pop in one cycle: fifo_count is unchanged and the byte order is preserved.
- Pop from STOP→START while FIFO is full: tx_ready rises on the following cycle.
- FIFO pointers wrap modulo FIFO_DEPTH; the extra count bit distinguishes full from empty.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps; it is reset on every state entry.
- tx_data is sampled only at push. Later changes to tx_data do not affect queued bytes.

Test Plan:
- CLKS_PER_BIT=4: push 0x55 from idle → tx=1 until the edge after the push, then 4 cycles of 0, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then 4 cycles of 1. tx_busy is high for 40 cycles, then returns to IDLE.
- Push 0xA3, 0x0F, 0xFF on consecutive cycles → three frames with no idle gap between stop and start.
  - Decoded LSB-first the frames are A3, 0F, FF.
  - fifo_count goes 0,1,1,2 → decrements at each frame boundary.
- FIFO_DEPTH=4: during the first frame push 5 bytes while tx_valid is held high → 4 are accepted and tx_ready drops. The 5th is held off and accepted in the cycle after the next pop. All 6 bytes (1 in flight + 5) go out in order.
- Assert reset for 1 cycle during DATA bit 3 with 2 bytes queued → next cycle tx=1, tx_busy=0, fifo_count=0, tx_ready=1. No further frames are sent.
- Push on the same edge as the STOP→START pop with count=2 → count stays 2 and the ordering is verified.
- tx_valid=1 with tx_ready=0 and the data changing → no byte is accepted and the queued frames are unaffected.
